// File: rtl/disp_axi_rdarb.sv
// disp_axi_rdarb: shares one AXI read master port between the display VRAM
// reader (requester 0) and a drawing/engine reader (requester 1). One burst
// is in flight at a time. Requester 0 normally wins, but after MAX_CONSEC
// back-to-back wins while requester 1 waits, requester 1 gets the next slot.
// The number of R beats in each burst is also checked against the latched ARLEN.
module disp_axi_rdarb #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_CONSEC = 4
) (
   input  logic                  ACLK,
   input  logic                  ARST,

   input  logic [ADDR_WIDTH-1:0] REQ0_ARADDR,
   input  logic [7:0]            REQ0_ARLEN,
   input  logic                  REQ0_ARVALID,
   output logic                  REQ0_ARREADY,
   output logic [DATA_WIDTH-1:0] REQ0_RDATA,
   output logic                  REQ0_RLAST,
   output logic                  REQ0_RVALID,
   input  logic                  REQ0_RREADY,

   input  logic [ADDR_WIDTH-1:0] REQ1_ARADDR,
   input  logic [7:0]            REQ1_ARLEN,
   input  logic                  REQ1_ARVALID,
   output logic                  REQ1_ARREADY,
   output logic [DATA_WIDTH-1:0] REQ1_RDATA,
   output logic                  REQ1_RLAST,
   output logic                  REQ1_RVALID,
   input  logic                  REQ1_RREADY,

   output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [7:0]            M_AXI_ARLEN,
   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic                  M_AXI_RLAST,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY,

   output logic                  GRANT,
   output logic                  BUSY,
   output logic                  LEN_ERR
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;

   localparam logic [3:0] C_MAX = 4'(MAX_CONSEC);

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic [7:0]            r_arlen;
   logic                  r_arvalid;
   logic                  r_grant;
   logic                  r_lenErr;
   logic [3:0]            r_consec;
   logic [8:0]            r_beatCnt;

   logic w_inIdle;
   logic w_inAddr;
   logic w_inData;
   logic w_pick1;
   logic w_grantAny;
   logic w_arHs;
   logic w_rReady;
   logic w_rHs;
   logic w_lenBad;

   assign w_inIdle   = (r_state == S_IDLE);
   assign w_inAddr   = (r_state == S_ADDR);
   assign w_inData   = (r_state == S_DATA);

   // Requester 1 wins when it is alone, or when requester 0 has used up its
   // allowance of consecutive wins while requester 1 was waiting.
   assign w_pick1    = REQ1_ARVALID && (!REQ0_ARVALID || (r_consec == C_MAX));
   assign w_grantAny = w_inIdle && (REQ0_ARVALID || REQ1_ARVALID);

   assign w_arHs     = w_inAddr && r_arvalid && M_AXI_ARREADY;
   assign w_rReady   = w_inData && (r_grant ? REQ1_RREADY : REQ0_RREADY);
   assign w_rHs      = w_rReady && M_AXI_RVALID;

   // A beat is inconsistent if RLAST arrives early or late relative to the
   // beat index; r_beatCnt is the number of beats already accepted.
   assign w_lenBad   = w_rHs && (M_AXI_RLAST ? (r_beatCnt != {1'b0, r_arlen})
                                             : (r_beatCnt == {1'b0, r_arlen}));

   // Main burst sequencer: arbitrate in IDLE, hold AR until accepted, then
   // pass R beats through until the beat carrying RLAST is accepted.
   always_ff @(posedge ACLK) begin
      if (ARST) begin
         r_state   <= S_IDLE;
         r_araddr  <= '0;
         r_arlen   <= '0;
         r_arvalid <= 1'b0;
         r_grant   <= 1'b0;
         r_beatCnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grantAny) begin
                  r_state   <= S_ADDR;
                  r_arvalid <= 1'b1;
                  r_grant   <= w_pick1;
                  r_araddr  <= w_pick1 ? REQ1_ARADDR : REQ0_ARADDR;
                  r_arlen   <= w_pick1 ? REQ1_ARLEN : REQ0_ARLEN;
               end
            end
            S_ADDR: begin
               if (w_arHs) begin
                  r_arvalid <= 1'b0;
                  r_beatCnt <= '0;
                  r_state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_rHs) begin
                  r_beatCnt <= r_beatCnt + 9'd1;
                  if (M_AXI_RLAST) begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_arvalid <= 1'b0;
            end
         endcase
      end
   end

   // Track consecutive requester-0 wins taken while requester 1 was waiting.
   always_ff @(posedge ACLK) begin
      if (ARST) begin
         r_consec <= '0;
      end else if (w_grantAny) begin
         if (!w_pick1 && REQ1_ARVALID) begin
            if (r_consec != C_MAX) begin
               r_consec <= r_consec + 4'd1;
            end
         end else begin
            r_consec <= '0;
         end
      end
   end

   // Sticky burst-length error flag, cleared only by reset.
   always_ff @(posedge ACLK) begin
      if (ARST) begin
         r_lenErr <= 1'b0;
      end else if (w_lenBad) begin
         r_lenErr <= 1'b1;
      end
   end

   assign M_AXI_ARADDR  = r_araddr;
   assign M_AXI_ARLEN   = r_arlen;
   assign M_AXI_ARVALID = r_arvalid;
   assign M_AXI_RREADY  = w_rReady;

   assign REQ0_ARREADY  = w_inAddr && !r_grant && M_AXI_ARREADY;
   assign REQ1_ARREADY  = w_inAddr &&  r_grant && M_AXI_ARREADY;

   assign REQ0_RDATA    = M_AXI_RDATA;
   assign REQ1_RDATA    = M_AXI_RDATA;
   assign REQ0_RVALID   = w_inData && !r_grant && M_AXI_RVALID;
   assign REQ1_RVALID   = w_inData &&  r_grant && M_AXI_RVALID;
   assign REQ0_RLAST    = w_inData && !r_grant && M_AXI_RLAST;
   assign REQ1_RLAST    = w_inData &&  r_grant && M_AXI_RLAST;

   assign GRANT         = r_grant;
   assign BUSY          = !w_inIdle;
   assign LEN_ERR       = r_lenErr;

endmodule

// File: doc/disp_axi_rdarb.md
Name: disp_axi_rdarb

Overview:
- Arbitrates one AXI read master port between two requesters: requester 0 is the display VRAM reader, requester 1 is a drawing/engine reader.
- Grants one complete burst at a time, with only one outstanding transaction.
- Requester 0 has priority, but a starvation guard ensures requester 1 is eventually served.
- Sits between the read-side controllers and the M_AXI_AR*/R* pins of the display top. It also checks burst length consistency.

Parameters:
- ADDR_WIDTH, 32, AR address width
- DATA_WIDTH, 64, R data width
- MAX_CONSEC, 4, maximum consecutive requester-0 grants while requester 1 is pending (range 1..15)

Ports:
- ACLK  in  1  system clock
- ARST  in  1  synchronous active-high reset
- REQ0_ARADDR  in  ADDR_WIDTH  requester 0 burst address
- REQ0_ARLEN  in  8  requester 0 burst length-1
- REQ0_ARVALID  in  1  requester 0 address valid
- REQ0_ARREADY  out  1  requester 0 address accepted
- REQ0_RDATA  out  DATA_WIDTH  read data to requester 0
- REQ0_RLAST  out  1  last beat to requester 0
- REQ0_RVALID  out  1  data valid to requester 0
- REQ0_RREADY  in  1  requester 0 data ready
- REQ1_ARADDR, REQ1_ARLEN, REQ1_ARVALID, REQ1_ARREADY, REQ1_RDATA, REQ1_RLAST, REQ1_RVALID, REQ1_RREADY: same widths and meanings as requester 0, for requester 1
- M_AXI_ARADDR  out  ADDR_WIDTH  AR address to AXI
- M_AXI_ARLEN  out  8  AR length to AXI
- M_AXI_ARVALID  out  1  AR valid to AXI
- M_AXI_ARREADY  in  1  AR ready from AXI
- M_AXI_RDATA  in  DATA_WIDTH  R data from AXI
- M_AXI_RLAST  in  1  R last from AXI
- M_AXI_RVALID  in  1  R valid from AXI
- M_AXI_RREADY  out  1  R ready to AXI
- GRANT  out  1  index of current or last granted requester
- BUSY  out  1  arbiter is not in IDLE
- LEN_ERR  out  1  sticky: burst beat count mismatched ARLEN

Behaviour:
- Clock and reset: one clock, ACLK. Reset ARST is synchronous and active-high.
- Reset values: state=IDLE; M_AXI_ARVALID=0; M_AXI_ARADDR=0; M_AXI_ARLEN=0; GRANT=0; BUSY=0; LEN_ERR=0; consec counter=0; beat counter=0.
- Reset mid-burst: return to IDLE immediately and drop all valids. Requesters are reset by the same ARST.
- FSM states: IDLE, ADDR, DATA.
- IDLE arbitration:
  - Neither REQx_ARVALID set: stay in IDLE.
  - Only one requester valid: grant it.
  - Both valid: grant 1 if consec==MAX_CONSEC, else grant 0.
  - On grant: latch REQx_ARADDR/ARLEN into M_AXI_ARADDR/ARLEN, set GRANT, set M_AXI_ARVALID=1, go to ADDR.
  - Latency: ARVALID is seen at AXI 1 cycle after the request is seen in IDLE.
- Consec counter:
  - Increments on a grant to requester 0 while REQ1_ARVALID=1.
  - Clears on any grant to requester 1, and on a requester-0 grant while REQ1_ARVALID=0.
  - Saturates at MAX_CONSEC.
- ADDR state:
  - M_AXI_ARVALID is held with a stable address until M_AXI_ARREADY.
  - REQ[GRANT]_ARREADY = M_AXI_ARREADY; the other requester's ARREADY = 0.
  - On handshake: ARVALID goes to 0 next cycle, beat counter clears, go to DATA.
- DATA state routing:
  - M_AXI_RDATA goes to both REQx_RDATA.
  - REQ[GRANT]_RVALID = M_AXI_RVALID and REQ[GRANT]_RLAST = M_AXI_RLAST; the other requester's RVALID and RLAST = 0.
  - M_AXI_RREADY = REQ[GRANT]_RREADY. The path is combinational, with zero added latency.
- DATA state beat handling:
  - The beat counter increments on each RVALID&RREADY handshake.
  - On the handshake carrying RLAST, go to IDLE. There is one bubble cycle before the next AR is issued.
  - Outside DATA: M_AXI_RREADY=0 and both REQx_RVALID=0. Stray R beats are not accepted.
- Length check: LEN_ERR is set if either condition holds, and stays set until ARST:
  - RLAST is handshaken while count != ARLEN.
  - A handshake occurs with count == ARLEN and RLAST=0.
  - The burst still completes on the actual RLAST.
- ARLEN=0: a single-beat burst is legal; the first beat must carry RLAST.
- BUSY = (state != IDLE). GRANT holds its value in IDLE.
- Requester valid dropped before grant: no effect. The arbiter samples only in IDLE.

Test Plan:
- Single requester 0, ARADDR=0x20001000, ARLEN=31, ARREADY after 3 cycles, 32 beats -> one AR with that address/length; REQ0 receives 32 beats with RLAST on beat 32; REQ1_RVALID stays 0; BUSY falls the cycle after RLAST.
- Both requesters continuously valid, MAX_CONSEC=4 -> grant order 0,0,0,0,1,0,0,0,0,1; each AR is issued only after the previous RLAST plus one idle cycle.
- Requester 1 alone, RREADY toggled every other cycle during an 8-beat burst (ARLEN=7) -> M_AXI_RREADY mirrors REQ1_RREADY exactly; 8 handshakes; no data lost.
- ARLEN=7 with RLAST on beat 6 -> LEN_ERR rises, FSM returns to IDLE; next clean burst completes and LEN_ERR stays 1 until ARST.
- ARST asserted in DATA after 5 of 32 beats -> next cycle state is IDLE, all valids are 0, LEN_ERR=0, GRANT=0; new request is granted normally.
- ARLEN=0 single beat with RLAST -> one handshake, no LEN_ERR, return to IDLE.
